axi_burst_bridge: RTL and testbench
===================================

# axi_burst_bridge

Converts the core's cache refill and writeback requests into AXI4 burst transactions on the Furina `axi4_mst` master interface. It sits directly upstream of the top-level AXI ports: it is the last block before the core's AR/R/AW/W/B channels. It has one read engine and one write engine, each allowing a single outstanding transaction, and they run concurrently. Both engines use fixed AXI IDs, INCR bursts, and full-width beats.

## Interface
Parameters:
- `ADDR_W`, 32, AXI address width.
- `DATA_W`, 32, AXI data width. Beat size is `log2(DATA_W/8)`.
- `ID_W`, 4, AXI ID width.
- `RD_ID`, 0, ID driven on `arid`.
- `WR_ID`, 1, ID driven on `awid` and `wid`.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset; synchronous, active-low.
- `rd_req_valid` / `rd_req_ready`  in/out  1  refill request handshake.
- `rd_req_addr`  in  ADDR_W  burst start address (beat-aligned).
- `rd_req_len`  in  8  beats minus 1 (AXI `arlen` encoding).
- `rd_rsp_valid` / `rd_rsp_ready`  out/in  1  refill data handshake.
- `rd_rsp_data`  out  DATA_W  refill beat.
- `rd_rsp_last`  out  1  final beat of the burst.
- `wr_req_valid` / `wr_req_ready`  in/out  1  writeback request handshake.
- `wr_req_addr`  in  ADDR_W  writeback start address.
- `wr_req_len`  in  8  beats minus 1.
- `wr_data_valid` / `wr_data_ready`  in/out  1  writeback data handshake.
- `wr_data`  in  DATA_W  writeback beat.
- `wr_strb`  in  DATA_W/8  byte strobes.
- `wr_done`  out  1  one-cycle pulse when the B response is accepted.
- `bus_err`  out  1  sticky error flag (see Configuration).
- AXI AR channel: `arid`, `araddr`, `arlen`, `arsize`, `arburst`, `arlock`, `arcache`, `arprot`, `arvalid` out; `arready` in. Widths are 4/32/8/3/2/2/4/3/1.
- AXI R channel: `rid`, `rdata`, `rresp`, `rlast`, `rvalid` in; `rready` out.
- AXI AW channel: same fields as AR, `aw*` prefix.
- AXI W channel: `wid`, `wdata`, `wstrb`, `wlast`, `wvalid` out; `wready` in.
- AXI B channel: `bid`, `bresp`, `bvalid` in; `bready` out.

## Operation
Constant AXI fields:
- `arburst`/`awburst` = 2'b01 (INCR).
- `arlock`/`awlock` = 0.
- `arcache`/`awcache` = 4'b0000.
- `arprot`/`awprot` = 3'b000.
- `arsize`/`awsize` = log2(DATA_W/8).

Read FSM, states R_IDLE, R_AR, R_DATA:
- R_IDLE: `rd_req_ready` = 1. On `rd_req_valid`, latch addr/len into `araddr`/`arlen` and go to R_AR.
- R_AR: `arvalid` = 1, with `araddr`/`arlen` held stable. On `arready`, go to R_DATA.
- R_DATA: `rd_rsp_valid` = `rvalid`, `rready` = `rd_rsp_ready`, `rd_rsp_data` = `rdata`, `rd_rsp_last` = `rlast`. Combinational pass-through.
- On the handshake with `rlast` = 1, go to R_IDLE.

Write FSM, states W_IDLE, W_AW, W_DATA, W_RESP:
- W_IDLE: `wr_req_ready` = 1. On `wr_req_valid`, latch addr/len, clear the beat counter, and go to W_AW.
- W_AW: `awvalid` = 1. On `awready`, go to W_DATA.
- W_DATA: `wvalid` = `wr_data_valid`, `wr_data_ready` = `wready`, `wdata`/`wstrb` pass through.
- `wlast` = (beat counter == latched len). The counter is 8-bit and increments on each W handshake.
- On the handshake with `wlast`, go to W_RESP.
- W_RESP: `bready` = 1. On `bvalid`, pulse `wr_done` for one cycle and go to W_IDLE.

Other rules:
- The two engines are independent. Read and write transactions may overlap in any cycle.
- `rid`/`bid` are not checked. Only one transaction per direction is ever outstanding.
- Ready/valid signals outside the states listed above are 0.

## Timing
- Reset values: all FSMs idle. `arvalid`, `awvalid`, `wvalid`, `rready`, `bready`, `wr_done`, `bus_err`, `rd_rsp_valid` are 0. `rd_req_ready` and `wr_req_ready` are 1. Address/len registers are 0.
- Request accept to `arvalid`/`awvalid` high: 1 cycle.
- R and W data paths: 0-cycle latency, combinational.
- B handshake to `wr_done`: pulse in the next cycle. A new `wr_req` is accepted in that same cycle.
- Back-to-back requests: a new request is accepted in the cycle after the FSM returns to idle. Minimum gap between read bursts is 1 idle cycle.
- A single-beat burst (len = 0) asserts `wlast` on the first beat.
- Reset asserted mid-burst: all FSMs return to idle on the next edge and all valids drop. The whole core resets together, so no drain is performed.

## Configuration
- `FURINA_AXI_RESP_ERR_EN` defined:
  - `bus_err` is set on any R handshake with `rresp` != 2'b00, or any B handshake with `bresp` != 2'b00.
  - It stays set until reset.
  - The burst still completes normally.
- `FURINA_AXI_RESP_ERR_EN` undefined: `bus_err` is tied to 0 and `rresp`/`bresp` are ignored.

## Test plan
- Read, `rd_req_addr` = 0x1C000000, len = 3, `arready` immediate: expect `arvalid` one cycle after accept with `arlen` = 3 and `arsize` = 2. Four R beats pass through, `rd_rsp_last` on beat 4, and the FSM is back in idle the next cycle.
- Write, addr 0x00001000, len = 7, `wready` toggling 1/0: expect exactly 8 W beats, `wlast` only on the 8th, `wid` = 1, then `bready`. After `bvalid`, `wr_done` pulses for one cycle.
- Concurrent read (len 0) and write (len 0) requests in the same cycle: expect both `arvalid` and `awvalid` the next cycle, and both transactions complete independently.
- `arready` held low for 5 cycles: expect `arvalid`, `araddr`, `arlen` stable throughout and `rd_req_ready` = 0.
- With `FURINA_AXI_RESP_ERR_EN` defined: `bresp` = 2'b10 sets `bus_err`; a following OKAY transaction leaves it at 1. Without the macro, `bus_err` stays 0.
- `aresetn` low for one cycle during beat 2 of a 4-beat write: expect all valids 0 and both ready outputs 1 on the next edge, and a fresh request accepted afterwards.

Source files
------------

// File: rtl/axi_burst_bridge.sv
// Converts cache refill/writeback requests into single-outstanding AXI4 INCR bursts.
// Optional macro FURINA_AXI_RESP_ERR_EN enables the sticky bus_err flag on non-OKAY responses.
module axi_burst_bridge #(
  parameter int          ADDR_W = 32,
  parameter int          DATA_W = 32,
  parameter int          ID_W   = 4,
  parameter int unsigned RD_ID  = 0,
  parameter int unsigned WR_ID  = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // refill request / response
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_W-1:0]     rd_req_addr,
  input  logic [7:0]            rd_req_len,
  output logic                  rd_rsp_valid,
  input  logic                  rd_rsp_ready,
  output logic [DATA_W-1:0]     rd_rsp_data,
  output logic                  rd_rsp_last,
  // writeback request / data
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [ADDR_W-1:0]     wr_req_addr,
  input  logic [7:0]            wr_req_len,
  input  logic                  wr_data_valid,
  output logic                  wr_data_ready,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  output logic                  wr_done,
  output logic                  bus_err,
  // AXI AR
  output logic [ID_W-1:0]       arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  // AXI R
  input  logic [ID_W-1:0]       rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  // AXI AW
  output logic [ID_W-1:0]       awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  // AXI W
  output logic [ID_W-1:0]       wid,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  // AXI B
  input  logic [ID_W-1:0]       bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam logic [2:0] AXSIZE = 3'($clog2(DATA_W/8));

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_e;

  r_state_e   r_state, r_next;
  w_state_e   w_state, w_next;
  logic [7:0] beat_cnt;

  assign arid    = ID_W'(RD_ID);
  assign arsize  = AXSIZE;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign awid    = ID_W'(WR_ID);
  assign wid     = ID_W'(WR_ID);
  assign awsize  = AXSIZE;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  assign rd_rsp_data = rdata;
  assign rd_rsp_last = rlast;
  assign wdata       = wr_data;
  assign wstrb       = wr_strb;

  // ---------------- read engine ----------------
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      araddr  <= '0;
      arlen   <= '0;
    end else begin
      r_state <= r_next;
      if (rd_req_valid && rd_req_ready) begin
        araddr <= rd_req_addr;
        arlen  <= rd_req_len;
      end
    end
  end

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    r_next       = r_state;
    rd_req_ready = 1'b0;
    arvalid      = 1'b0;
    rd_rsp_valid = 1'b0;
    rready       = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        rd_req_ready = 1'b1;
        if (rd_req_valid) r_next = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) r_next = R_DATA;
      end
      R_DATA: begin
        rd_rsp_valid = rvalid;
        rready       = rd_rsp_ready;
        if (rvalid && rd_rsp_ready && rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // ---------------- write engine ----------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state  <= W_IDLE;
      awaddr   <= '0;
      awlen    <= '0;
      beat_cnt <= '0;
      wr_done  <= 1'b0;
    end else begin
      w_state <= w_next;
      wr_done <= bvalid && bready;
      if (wr_req_valid && wr_req_ready) begin
        awaddr   <= wr_req_addr;
        awlen    <= wr_req_len;
        beat_cnt <= '0;
      end else if (wvalid && wready) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_next        = w_state;
    wr_req_ready  = 1'b0;
    awvalid       = 1'b0;
    wvalid        = 1'b0;
    wr_data_ready = 1'b0;
    wlast         = 1'b0;
    bready        = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        wr_req_ready = 1'b1;
        if (wr_req_valid) w_next = W_AW;
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) w_next = W_DATA;
      end
      W_DATA: begin
        wvalid        = wr_data_valid;
        wr_data_ready = wready;
        wlast         = (beat_cnt == awlen);
        if (wr_data_valid && wready && wlast) w_next = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // ---------------- response error flag ----------------
`ifdef FURINA_AXI_RESP_ERR_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bus_err <= 1'b0;
    end else if ((rvalid && rready && (rresp != 2'b00)) ||
                 (bvalid && bready && (bresp != 2'b00))) begin
      bus_err <= 1'b1;
    end
  end

  logic unused_ids;
  assign unused_ids = ^{rid, bid};
`else
  assign bus_err = 1'b0;

  logic unused_rsp;
  assign unused_rsp = ^{rid, bid, rresp, bresp};
`endif

endmodule

// File: tb/tb_axi_burst_bridge.sv
// Directed bench for axi_burst_bridge: expected AXI/core-side transfers are queued by the
// stimulus and popped by a negedge monitor whenever the DUT completes a handshake.
module tb_axi_burst_bridge;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        rd_req_valid, rd_req_ready;
  logic [31:0] rd_req_addr;
  logic [7:0]  rd_req_len;
  logic        rd_rsp_valid, rd_rsp_ready;
  logic [31:0] rd_rsp_data;
  logic        rd_rsp_last;
  logic        wr_req_valid, wr_req_ready;
  logic [31:0] wr_req_addr;
  logic [7:0]  wr_req_len;
  logic        wr_data_valid, wr_data_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_done, bus_err;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

`ifdef FURINA_AXI_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  axi_burst_bridge dut (
    .aclk(aclk), .aresetn(aresetn),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
    .rd_rsp_data(rd_rsp_data), .rd_rsp_last(rd_rsp_last),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_done(wr_done), .bus_err(bus_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ax_t;
  typedef struct packed { logic [31:0] data; logic last; } r_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } w_t;

  ax_t exp_ar[$];
  ax_t exp_aw[$];
  r_t  exp_r[$];
  w_t  exp_w[$];
  int  exp_done = 0;
  int  tests    = 0;
  int  fails    = 0;

  ax_t mon_ax;
  r_t  mon_r;
  w_t  mon_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  // Scoreboard monitor: compares every completed handshake with the queued expectation.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (arvalid && arready) begin
        check("ar_expected", exp_ar.size() != 0, 1);
        if (exp_ar.size() != 0) begin
          mon_ax = exp_ar.pop_front();
          check("araddr", araddr, mon_ax.addr);
          check("arlen", arlen, mon_ax.len);
          check("arsize", arsize, 2);
          check("arburst", arburst, 1);
          check("arid", arid, 0);
          check("ar_const", {arlock, arcache, arprot}, 0);
        end
      end
      if (awvalid && awready) begin
        check("aw_expected", exp_aw.size() != 0, 1);
        if (exp_aw.size() != 0) begin
          mon_ax = exp_aw.pop_front();
          check("awaddr", awaddr, mon_ax.addr);
          check("awlen", awlen, mon_ax.len);
          check("awsize", awsize, 2);
          check("awburst", awburst, 1);
          check("awid", awid, 1);
          check("aw_const", {awlock, awcache, awprot}, 0);
        end
      end
      if (rd_rsp_valid && rd_rsp_ready) begin
        check("r_expected", exp_r.size() != 0, 1);
        check("rready", rready, 1);
        if (exp_r.size() != 0) begin
          mon_r = exp_r.pop_front();
          check("rd_rsp_data", rd_rsp_data, mon_r.data);
          check("rd_rsp_last", rd_rsp_last, mon_r.last);
        end
      end
      if (wvalid && wready) begin
        check("w_expected", exp_w.size() != 0, 1);
        check("wr_data_ready", wr_data_ready, 1);
        if (exp_w.size() != 0) begin
          mon_w = exp_w.pop_front();
          check("wdata", wdata, mon_w.data);
          check("wstrb", wstrb, mon_w.strb);
          check("wlast", wlast, mon_w.last);
          check("wid", wid, 1);
        end
      end
      if (wr_done) begin
        check("wr_done_expected", exp_done > 0, 1);
        if (exp_done > 0) exp_done--;
      end
    end
  end

  task automatic do_write_single(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [1:0] resp);
    wr_req_valid = 1'b1;
    wr_req_addr  = addr;
    wr_req_len   = 8'd0;
    exp_aw.push_back({addr, 8'd0});
    tick;
    wr_req_valid = 1'b0;
    tick;
    wr_data_valid = 1'b1;
    wr_data       = data;
    wr_strb       = 4'hF;
    wready        = 1'b1;
    exp_w.push_back({data, 4'hF, 1'b1});
    tick;
    wr_data_valid = 1'b0;
    bvalid        = 1'b1;
    bresp         = resp;
    exp_done++;
    tick;
    bvalid = 1'b0;
    bresp  = 2'b00;
    check("single_wr_done", wr_done, 1);
  endtask

  initial begin
    int beat;
    int cyc;
    aresetn = 1'b0;
    rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_len = '0; rd_rsp_ready = 1'b1;
    wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_len = '0;
    wr_data_valid = 1'b0; wr_data = '0; wr_strb = '0;
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    bid = '0; bresp = '0; bvalid = 1'b0;
    repeat (3) tick;

    // reset state
    check("rst_valids", {arvalid, awvalid, wvalid, rready, bready, wr_done, bus_err, rd_rsp_valid}, 0);
    check("rst_rd_req_ready", rd_req_ready, 1);
    check("rst_wr_req_ready", wr_req_ready, 1);
    check("rst_addr_len", {araddr, arlen, awaddr, awlen}, 0);
    aresetn = 1'b1;
    tick;

    // 4-beat read, immediate arready
    rd_req_valid = 1'b1; rd_req_addr = 32'h1C00_0000; rd_req_len = 8'd3;
    #1 check("t1_req_ready", rd_req_ready, 1);
    exp_ar.push_back({32'h1C00_0000, 8'd3});
    tick;
    rd_req_valid = 1'b0;
    check("t1_arvalid", arvalid, 1);
    check("t1_busy", rd_req_ready, 0);
    tick;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1; rdata = 32'hA0A0_0000 + i; rlast = (i == 3); rresp = 2'b00;
      exp_r.push_back({32'hA0A0_0000 + i, i == 3});
      tick;
    end
    rvalid = 1'b0; rlast = 1'b0;
    check("t1_idle", rd_req_ready, 1);

    // 8-beat write with wready toggling
    wr_req_valid = 1'b1; wr_req_addr = 32'h0000_1000; wr_req_len = 8'd7;
    exp_aw.push_back({32'h0000_1000, 8'd7});
    tick;
    wr_req_valid = 1'b0;
    check("t2_awvalid", awvalid, 1);
    tick;
    beat = 0;
    cyc  = 0;
    while (beat < 8 && cyc < 64) begin
      wr_data_valid = 1'b1;
      wr_data       = 32'hB000_0000 + beat;
      wr_strb       = beat[0] ? 4'h3 : 4'hC;
      wready        = (cyc % 2 == 0);
      if (wready) exp_w.push_back({32'hB000_0000 + beat, beat[0] ? 4'h3 : 4'hC, beat == 7});
      tick;
      if (wready) beat++;
      cyc++;
    end
    wr_data_valid = 1'b0;
    wready        = 1'b1;
    #1;
    check("t2_bready", bready, 1);
    check("t2_wvalid_low", wvalid, 0);
    bvalid = 1'b1; bresp = 2'b00;
    exp_done++;
    tick;
    bvalid = 1'b0;
    check("t2_wr_done", wr_done, 1);
    check("t2_wr_req_ready", wr_req_ready, 1);
    tick;
    check("t2_done_one_cycle", wr_done, 0);

    // concurrent single-beat read and write
    rd_req_valid = 1'b1; rd_req_addr = 32'h0000_0200; rd_req_len = 8'd0;
    wr_req_valid = 1'b1; wr_req_addr = 32'h0000_0300; wr_req_len = 8'd0;
    exp_ar.push_back({32'h0000_0200, 8'd0});
    exp_aw.push_back({32'h0000_0300, 8'd0});
    tick;
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    check("t3_both_valid", {arvalid, awvalid}, 2'b11);
    tick;
    rvalid = 1'b1; rdata = 32'hC0DE_0001; rlast = 1'b1;
    exp_r.push_back({32'hC0DE_0001, 1'b1});
    wr_data_valid = 1'b1; wr_data = 32'hD00D_0001; wr_strb = 4'hF;
    exp_w.push_back({32'hD00D_0001, 4'hF, 1'b1});
    tick;
    rvalid = 1'b0; rlast = 1'b0; wr_data_valid = 1'b0;
    check("t3_rd_idle", rd_req_ready, 1);
    check("t3_bready", bready, 1);
    bvalid = 1'b1;
    exp_done++;
    tick;
    bvalid = 1'b0;
    check("t3_wr_done", wr_done, 1);

    // arready stalled for 5 cycles
    arready = 1'b0;
    rd_req_valid = 1'b1; rd_req_addr = 32'h2000_0040; rd_req_len = 8'd1;
    exp_ar.push_back({32'h2000_0040, 8'd1});
    tick;
    rd_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t4_ar_hold", {arvalid, araddr, arlen, rd_req_ready}, {1'b1, 32'h2000_0040, 8'd1, 1'b0});
      tick;
    end
    arready = 1'b1;
    tick;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rdata = 32'h5500_0000 + i; rlast = (i == 1);
      exp_r.push_back({32'h5500_0000 + i, i == 1});
      tick;
    end
    rvalid = 1'b0; rlast = 1'b0;

    // error response handling
    do_write_single(32'h0000_0400, 32'h1111_2222, 2'b10);
    check("t5_bus_err_set", bus_err, ERR_EN);
    do_write_single(32'h0000_0404, 32'h3333_4444, 2'b00);
    check("t5_bus_err_sticky", bus_err, ERR_EN);

    // reset during beat 2 of a 4-beat write, with a stalled read also pending
    arready = 1'b0;
    rd_req_valid = 1'b1; rd_req_addr = 32'h0000_5000; rd_req_len = 8'd0;
    wr_req_valid = 1'b1; wr_req_addr = 32'h0000_3000; wr_req_len = 8'd3;
    exp_aw.push_back({32'h0000_3000, 8'd3});
    tick;
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    tick;
    wr_data_valid = 1'b1; wr_data = 32'hE000_0000; wr_strb = 4'hF; wready = 1'b1;
    exp_w.push_back({32'hE000_0000, 4'hF, 1'b0});
    tick;
    wr_data = 32'hE000_0001; wready = 1'b0;
    aresetn = 1'b0;
    tick;
    check("t6_valids_low", {arvalid, awvalid, wvalid, rd_rsp_valid, rready, bready, wr_done}, 0);
    check("t6_readies", {rd_req_ready, wr_req_ready}, 2'b11);
    check("t6_bus_err_cleared", bus_err, 0);
    aresetn = 1'b1; wr_data_valid = 1'b0; wready = 1'b1; arready = 1'b1;
    tick;
    do_write_single(32'h0000_3100, 32'h7777_8888, 2'b00);

    repeat (3) tick;
    check("drain_ar", exp_ar.size(), 0);
    check("drain_aw", exp_aw.size(), 0);
    check("drain_r", exp_r.size(), 0);
    check("drain_w", exp_w.size(), 0);
    check("drain_done", exp_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
